// File: rtl/cpr_pkg.sv
// cpr_sched shared types: FSM state, entry bundle and default widths.
// Optional aging build: define CPR_SCHED_AGING_EN.
package cpr_pkg;

  localparam int TW_D      = 2;
  localparam int FDSSI_W_D = 12;
  localparam int SSI_W_D   = 8;
  localparam int S_W_D     = 2;
  localparam int AGE_W_D   = 2;
  localparam int AGE_MAX_D = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 wt;
    logic [FDSSI_W_D-1:0] fdssi;
    logic [SSI_W_D-1:0]   ssi;
    logic [S_W_D-1:0]     s;
  } entry_t;

endpackage

// File: rtl/cpr_sel2.sv
// Two-entry select: asserts take when cand beats best.
// Urgency inputs exist only with CPR_SCHED_AGING_EN.
module cpr_sel2
  import cpr_pkg::*;
(
  input  entry_t cand,
  input  entry_t best,
`ifdef CPR_SCHED_AGING_EN
  input  logic   cand_urg,
  input  logic   best_urg,
`endif
  output logic   take
);

  logic better;

  always_comb begin
    better = (cand.s < best.s) ||
             ((cand.s == best.s) && cand.wt && !best.wt);
`ifdef CPR_SCHED_AGING_EN
    // urgency dominates cost; equal urgency falls back to cost
    if (cand_urg != best_urg) better = cand_urg;
`endif
    take = cand.valid && (!best.valid || better);
  end

endmodule

// File: rtl/cpr_sched.sv
// Sequential min-cost scheduler, one entry per cycle via cpr_sel2.
// Optional per-requester aging: define CPR_SCHED_AGING_EN.
module cpr_sched
  import cpr_pkg::*;
#(
  parameter int TW      = TW_D,
  parameter int FDSSI_W = FDSSI_W_D,
  parameter int SSI_W   = SSI_W_D,
  parameter int S_W     = S_W_D,
  parameter int AGE_W   = AGE_W_D,
  parameter int AGE_MAX = AGE_MAX_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  input  logic [(1<<TW)-1:0]     valid,
  input  logic [(1<<TW)-1:0]     wt,
  input  logic [FDSSI_W*(1<<TW)-1:0] FDSSI,
  input  logic [SSI_W*(1<<TW)-1:0]   SSI,
  input  logic [S_W*(1<<TW)-1:0]     s,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   valid_o,
  output logic                   wt_o,
  output logic [FDSSI_W-1:0]     FDSSI_o,
  output logic [SSI_W-1:0]       SSI_o,
  output logic [S_W-1:0]         s_o,
  output logic [TW-1:0]          FDSTI_o,
  output logic [(1<<TW)-1:0]     grant
);

  localparam int N = 1 << TW;

  if (AGE_MAX > (2**AGE_W) - 1) begin : g_bad_age
    $error("AGE_MAX exceeds AGE_W range");
  end

  state_t         state;
  entry_t         snap [N];
  logic [TW-1:0]  idx;
  logic [TW-1:0]  best_idx;
  entry_t         best;
  entry_t         cand;
  entry_t         nxt;
  logic [TW-1:0]  nxt_idx;
  logic           take;

  assign cand    = snap[idx];
  assign nxt     = take ? cand : best;
  assign nxt_idx = take ? idx : best_idx;

`ifdef CPR_SCHED_AGING_EN
  logic [AGE_W-1:0] age [N];
  logic             cand_urg;
  logic             best_urg;

  assign cand_urg = (age[idx] == AGE_W'(AGE_MAX));
  assign best_urg = (age[best_idx] == AGE_W'(AGE_MAX));

  cpr_sel2 u_sel (
    .cand     (cand),
    .best     (best),
    .cand_urg (cand_urg),
    .best_urg (best_urg),
    .take     (take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else if (state == HOLD && out_ready) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i])
          age[i] <= '0;
        else if (snap[i].valid && age[i] != AGE_W'(AGE_MAX))
          age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  cpr_sel2 u_sel (
    .cand (cand),
    .best (best),
    .take (take)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      valid_o   <= 1'b0;
      wt_o      <= 1'b0;
      FDSSI_o   <= '0;
      SSI_o     <= '0;
      s_o       <= '0;
      FDSTI_o   <= '0;
      grant     <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best      <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              snap[i].valid <= valid[i];
              snap[i].wt    <= wt[i];
              snap[i].fdssi <= FDSSI[FDSSI_W*i +: FDSSI_W];
              snap[i].ssi   <= SSI[SSI_W*i +: SSI_W];
              snap[i].s     <= s[S_W*i +: S_W];
            end
            idx      <= '0;
            best_idx <= '0;
            best     <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt;
          best_idx <= nxt_idx;
          idx      <= idx + 1'b1;
          if (idx == TW'(N-1)) begin
            // best is all-zero when nothing was valid
            out_valid <= 1'b1;
            valid_o   <= nxt.valid;
            wt_o      <= nxt.wt;
            FDSSI_o   <= nxt.fdssi;
            SSI_o     <= nxt.ssi;
            s_o       <= nxt.s;
            FDSTI_o   <= nxt_idx;
            grant     <= nxt.valid ?
                         ({{(N-1){1'b0}}, 1'b1} << nxt_idx) : '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpr_sched.sv
// Scoreboard bench for cpr_sched with a priority-key reference model.
// Mirrors CPR_SCHED_AGING_EN for the urgency rule.
module tb_cpr_sched;

  localparam int TW  = 2;
  localparam int N   = 4;
  localparam int FW  = 12;
  localparam int SW  = 8;
  localparam int CW  = 2;
  localparam int AMX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  valid = '0;
  logic [N-1:0]  wt = '0;
  logic [FW*N-1:0] fdssi = '0;
  logic [SW*N-1:0] ssi = '0;
  logic [CW*N-1:0] s = '0;
  logic          busy, out_valid, valid_o, wt_o;
  logic [FW-1:0] FDSSI_o;
  logic [SW-1:0] SSI_o;
  logic [CW-1:0] s_o;
  logic [TW-1:0] FDSTI_o;
  logic [N-1:0]  grant;

  cpr_sched #(
    .TW(TW), .FDSSI_W(FW), .SSI_W(SW), .S_W(CW),
    .AGE_W(2), .AGE_MAX(AMX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .valid(valid), .wt(wt), .FDSSI(fdssi), .SSI(ssi), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .valid_o(valid_o), .wt_o(wt_o), .FDSSI_o(FDSSI_o),
    .SSI_o(SSI_o), .s_o(s_o), .FDSTI_o(FDSTI_o), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v; int idx; int w; int fd; int sd; int c; int g;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   age [N];
  int   ready_mode = 2;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // lowest (cost, not-wt) key wins, first index on ties
  task automatic predict();
    exp_t e;
    int   win = -1;
    int   bk = 0;
    int   key;
    bit   urg = 0;
`ifdef CPR_SCHED_AGING_EN
    for (int i = 0; i < N; i++)
      if (valid[i] && age[i] == AMX) urg = 1;
`endif
    for (int i = 0; i < N; i++) begin
      if (!valid[i]) continue;
      if (urg && age[i] != AMX) continue;
      key = 2 * int'(s[CW*i +: CW]) + (wt[i] ? 0 : 1);
      if (win < 0 || key < bk) begin
        win = i;
        bk = key;
      end
    end
    e = '{default: 0};
    if (win >= 0) begin
      e.v   = 1;
      e.idx = win;
      e.w   = int'(wt[win]);
      e.fd  = int'(fdssi[FW*win +: FW]);
      e.sd  = int'(ssi[SW*win +: SW]);
      e.c   = int'(s[CW*win +: CW]);
      e.g   = 1 << win;
    end
`ifdef CPR_SCHED_AGING_EN
    for (int i = 0; i < N; i++)
      if (valid[i]) age[i] = (i == win) ? 0 : ((age[i] < AMX) ? age[i] + 1 : AMX);
`endif
    q.push_back(e);
  endtask

  task automatic scramble();
    valid = N'($urandom);
    wt    = N'($urandom);
    fdssi = (FW*N)'({$urandom, $urandom});
    ssi   = (SW*N)'($urandom);
    s     = (CW*N)'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_round();
    int k;
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    predict();
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", int'(busy), 1);
    scramble();
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, N + 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        chk("valid_o", int'(valid_o), e.v);
        chk("FDSTI_o", int'(FDSTI_o), e.idx);
        chk("grant", int'(grant), e.g);
        chk("s_o", int'(s_o), e.c);
        chk("wt_o", int'(wt_o), e.w);
        chk("FDSSI_o", int'(FDSSI_o), e.fd);
        chk("SSI_o", int'(SSI_o), e.sd);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_FDSTI_o", int'(FDSTI_o), 0);
    chk("rst_s_o", int'(s_o), 0);
    chk("rst_wt_o", int'(wt_o), 0);
    for (int i = 0; i < N; i++) age[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) age[i] = 0;
    #1;
    do_reset();

    valid = 4'hF; wt = 4'h0;
    s = {2'd1, 2'd2, 2'd1, 2'd3};
    run_round();
    valid = 4'hF; wt = 4'b1000;
    s = {2'd1, 2'd2, 2'd1, 2'd3};
    run_round();
    valid = 4'h0;
    run_round();

    ready_mode = 1;
    scramble();
    run_round();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      scramble();
      start = 1'(i % 2);
      chk("stall_busy", int'(busy), 1);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_FDSTI", int'(FDSTI_o), q[0].idx);
      chk("stall_grant", int'(grant), q[0].g);
      chk("stall_s_o", int'(s_o), q[0].c);
    end
    @(negedge clk);
    start = 1'b0;
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_busy", int'(busy), 0);
    chk("post_hs_out_valid", int'(out_valid), 0);

    @(negedge clk);
    wait_idle();
    scramble();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (N + 2) begin
      @(negedge clk);
      chk("abort_no_result", int'(out_valid), 0);
    end
    scramble();
    run_round();

`ifdef CPR_SCHED_AGING_EN
    @(negedge clk);
    wait_idle();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      valid = 4'b0101; wt = 4'h0;
      s = {2'd2, 2'd0, 2'd1, 2'd3};
      run_round();
    end
`endif

    ready_mode = 0;
    for (int r = 0; r < 60; r++) begin
      scramble();
      run_round();
    end

    ready_mode = 2;
    @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
